// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: parametrised UART receiver with a small receive FIFO.
//
// Frames are DATA_W data bits (LSB first), optional even/odd parity and one
// or two stop bits, with a run-time bit period of div_i clock cycles. Good
// frames are pushed into a FIFO_DEPTH-entry FIFO that is read through a
// valid/ready interface. Bad frames raise a one-cycle error pulse and are
// dropped. A line held low through the first stop bit is reported as a break.
//
// Ports:
//   clk_i, rstn_i      clock, asynchronous active-low reset
//   rx_i               serial line, idle high, asynchronous to clk_i
//   div_i              clock cycles per bit (values below 4 act as 4)
//   parity_i           00/01 none, 10 even, 11 odd
//   stop2_i            1 selects two stop bits
//   rd_data_o          registered FIFO head (0 when empty)
//   rd_valid_o         FIFO not empty
//   rd_ready_i         pop request, honoured while rd_valid_o is high
//   count_o            FIFO occupancy
//   frame_err_o        pulse: a stop bit was sampled low
//   parity_err_o       pulse: parity mismatch on an otherwise good frame
//   overflow_o         pulse: good frame dropped because the FIFO was full
//   break_o            level: line-break condition active
module uart_rx_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 32
) (
    input  logic                            clk_i,
    input  logic                            rstn_i,
    input  logic                            rx_i,
    input  logic [DIV_W-1:0]                div_i,
    input  logic [1:0]                      parity_i,
    input  logic                            stop2_i,
    output logic [DATA_W-1:0]               rd_data_o,
    output logic                            rd_valid_o,
    input  logic                            rd_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]     count_o,
    output logic                            frame_err_o,
    output logic                            parity_err_o,
    output logic                            overflow_o,
    output logic                            break_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_BREAK
    } state_t;

    // ---------------------------------------------------------------- sync
    logic rx_meta, rxs, rxs_prev;

    // NOTE: sequential state is always written with non-blocking assignments
    // so every flop samples the pre-edge value of its neighbours.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
        end else begin
            rx_meta  <= rx_i;
            rxs      <= rx_meta;
            rxs_prev <= rxs;
        end
    end

    // ------------------------------------------------------------ receiver
    state_t            state;
    logic [DIV_W-1:0]  cnt, f_div;
    logic              f_par_en, f_odd, f_stop2;
    logic [3:0]        bit_idx;
    logic [DATA_W-1:0] shreg;
    logic              par_acc, par_bad, all_zero;
    logic              push_r;

    logic [DIV_W-1:0] div_clamped;
    logic             tick;

    assign div_clamped = (div_i < DIV_W'(4)) ? DIV_W'(4) : div_i;
    // The counter is loaded with the wait length and the sample is taken on
    // the cycle it reads 1, so a load of N samples exactly N cycles later.
    assign tick = (cnt == DIV_W'(1));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state        <= S_IDLE;
            cnt          <= '0;
            f_div        <= DIV_W'(4);
            f_par_en     <= 1'b0;
            f_odd        <= 1'b0;
            f_stop2      <= 1'b0;
            bit_idx      <= '0;
            shreg        <= '0;
            par_acc      <= 1'b0;
            par_bad      <= 1'b0;
            all_zero     <= 1'b1;
            push_r       <= 1'b0;
            frame_err_o  <= 1'b0;
            parity_err_o <= 1'b0;
            break_o      <= 1'b0;
        end else begin
            push_r       <= 1'b0;
            frame_err_o  <= 1'b0;
            parity_err_o <= 1'b0;
            if (state != S_IDLE && state != S_BREAK)
                cnt <= tick ? f_div : cnt - DIV_W'(1);

            case (state)
                S_IDLE: begin
                    if (rxs_prev && !rxs) begin
                        f_div    <= div_clamped;
                        f_par_en <= parity_i[1];
                        f_odd    <= parity_i[0];
                        f_stop2  <= stop2_i;
                        cnt      <= div_clamped >> 1;
                        state    <= S_START;
                    end
                end
                S_START: if (tick) begin
                    if (rxs) begin
                        state <= S_IDLE;            // glitch, not a start bit
                    end else begin
                        bit_idx  <= '0;
                        par_acc  <= 1'b0;
                        par_bad  <= 1'b0;
                        all_zero <= 1'b1;
                        state    <= S_DATA;
                    end
                end
                S_DATA: if (tick) begin
                    shreg   <= {rxs, shreg[DATA_W-1:1]};
                    par_acc <= par_acc ^ rxs;
                    if (rxs) all_zero <= 1'b0;
                    bit_idx <= bit_idx + 4'd1;
                    if (bit_idx == 4'(DATA_W - 1))
                        state <= f_par_en ? S_PARITY : S_STOP1;
                end
                S_PARITY: if (tick) begin
                    par_bad <= ((par_acc ^ rxs) != f_odd);
                    if (rxs) all_zero <= 1'b0;
                    state <= S_STOP1;
                end
                S_STOP1: if (tick) begin
                    if (!rxs) begin
                        // An all-zero frame including its stop bit is a break.
                        if (all_zero) begin
                            break_o <= 1'b1;
                            state   <= S_BREAK;
                        end else begin
                            frame_err_o <= 1'b1;
                            state       <= S_IDLE;
                        end
                    end else if (f_stop2) begin
                        state <= S_STOP2;
                    end else begin
                        parity_err_o <= par_bad;
                        push_r       <= !par_bad;
                        state        <= S_IDLE;
                    end
                end
                S_STOP2: if (tick) begin
                    if (!rxs) begin
                        frame_err_o <= 1'b1;
                    end else begin
                        parity_err_o <= par_bad;
                        push_r       <= !par_bad;
                    end
                    state <= S_IDLE;
                end
                S_BREAK: begin
                    if (rxs) begin
                        break_o <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------- FIFO
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [CNT_W-1:0]  count_nxt;
    logic [DATA_W-1:0] head_nxt;
    logic              full, do_pop, do_push;

    assign full       = (count_o == CNT_W'(FIFO_DEPTH));
    assign rd_valid_o = (count_o != '0);
    assign do_pop     = rd_ready_i && rd_valid_o;
    // A full FIFO still accepts the push when a pop frees a slot this cycle.
    assign do_push    = push_r && (!full || do_pop);
    assign overflow_o = push_r && full && !do_pop;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        rd_ptr_nxt = do_pop ? rd_ptr + PTR_W'(1) : rd_ptr;
        count_nxt  = count_o + CNT_W'(do_push) - CNT_W'(do_pop);
        head_nxt   = '0;
        if (do_push && rd_ptr_nxt == wr_ptr)
            head_nxt = shreg;               // new head is being written now
        else if (count_nxt != '0)
            head_nxt = mem[rd_ptr_nxt];
    end

    // NOTE: the storage array has no reset; occupancy and the head register
    // are reset, so stale contents are never visible.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_o   <= '0;
            rd_data_o <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            rd_ptr    <= rd_ptr_nxt;
            count_o   <= count_nxt;
            rd_data_o <= head_nxt;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo. Main instance: DATA_W=8, FIFO_DEPTH=4.
// Second instance: DATA_W=7, FIFO_DEPTH=8, for the 7-bit/odd/2-stop case.
module tb_uart_rx_fifo;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic        rx = 1'b1;
    logic [31:0] div = 32'd8;
    logic [1:0]  par = 2'b00;
    logic        stop2 = 1'b0;
    logic        rdy = 1'b0;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic [2:0]  count;
    logic        ferr, perr, ovf, brk;

    // 7-bit instance
    logic        rx7 = 1'b1;
    logic [31:0] div7 = 32'd8;
    logic [1:0]  par7 = 2'b11;
    logic        stop2_7 = 1'b1;
    logic        rdy7 = 1'b0;
    logic [6:0]  rd_data7;
    logic        rd_valid7;
    logic [3:0]  count7;
    logic        ferr7, perr7, ovf7, brk7;

    uart_rx_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .DIV_W(32)) dut (
        .clk_i(clk), .rstn_i(rstn), .rx_i(rx), .div_i(div), .parity_i(par),
        .stop2_i(stop2), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
        .rd_ready_i(rdy), .count_o(count), .frame_err_o(ferr),
        .parity_err_o(perr), .overflow_o(ovf), .break_o(brk)
    );

    uart_rx_fifo #(.DATA_W(7), .FIFO_DEPTH(8), .DIV_W(32)) dut7 (
        .clk_i(clk), .rstn_i(rstn), .rx_i(rx7), .div_i(div7), .parity_i(par7),
        .stop2_i(stop2_7), .rd_data_o(rd_data7), .rd_valid_o(rd_valid7),
        .rd_ready_i(rdy7), .count_o(count7), .frame_err_o(ferr7),
        .parity_err_o(perr7), .overflow_o(ovf7), .break_o(brk7)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // event monitor, sampled on the falling edge
    int n_ferr = 0, n_perr = 0, n_ovf = 0, n_brk = 0, n_ferr7 = 0, n_perr7 = 0;
    logic brk_q = 1'b0;
    logic [7:0] popq[$];

    always @(negedge clk) begin
        if (ferr)  n_ferr++;
        if (perr)  n_perr++;
        if (ovf)   n_ovf++;
        if (brk && !brk_q) n_brk++;
        brk_q = brk;
        if (ferr7) n_ferr7++;
        if (perr7) n_perr7++;
        if (rd_valid && rdy) popq.push_back(rd_data);
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    // wait n rising edges, then step 1 time unit off the edge
    task automatic hold(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_rx(input bit line, input logic b);
        if (line) rx7 = b;
        else      rx  = b;
    endtask

    task automatic send_frame(input bit line, input logic [7:0] d, input int nbits,
                              input int bl, input bit par_en, input logic pb,
                              input logic s1, input bit use_s2, input logic s2,
                              input bit scramble);
        set_rx(line, 1'b0);
        hold(bl);
        if (scramble) begin
            div   = $urandom;
            par   = 2'($urandom_range(0, 3));
            stop2 = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < nbits; i++) begin
            set_rx(line, d[i]);
            hold(bl);
        end
        if (par_en) begin
            set_rx(line, pb);
            hold(bl);
        end
        set_rx(line, s1);
        hold(bl);
        if (use_s2) begin
            set_rx(line, s2);
            hold(bl);
        end
        set_rx(line, 1'b1);
    endtask

    task automatic send_8n1(input logic [7:0] d, input int bl);
        send_frame(1'b0, d, 8, bl, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic drain();
        int n = 0;
        rdy = 1'b1;
        while (rd_valid && n < 16) begin
            hold(1);
            n++;
        end
        rdy = 1'b0;
        hold(1);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rstn = 1'b0;
        hold(3);
        n_tests++;
        if ({count, rd_valid, rd_data, ferr, perr, ovf, brk} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got cnt=%0d v=%b d=%h fe=%b pe=%b ov=%b br=%b, want all 0",
                     count, rd_valid, rd_data, ferr, perr, ovf, brk);
        end
        rstn = 1'b1;
        hold(4);
    endtask

    task automatic test_basic();
        int b_ferr = n_ferr, b_perr = n_perr, b_ovf = n_ovf;
        div = 8; par = 2'b00; stop2 = 1'b0;
        send_8n1(8'hA5, 8);
        hold(10);
        n_tests++;
        if (count !== 3'd1 || rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_count: got cnt=%0d v=%b, want cnt=1 v=1", count, rd_valid);
        end
        n_tests++;
        if (rd_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL basic_data: got %h want a5", rd_data);
        end
        n_tests++;
        if (n_ferr != b_ferr || n_perr != b_perr || n_ovf != b_ovf) begin
            n_fail++;
            $display("FAIL basic_pulses: got fe=%0d pe=%0d ov=%0d extra, want 0",
                     n_ferr - b_ferr, n_perr - b_perr, n_ovf - b_ovf);
        end
        rdy = 1'b1;
        hold(1);
        rdy = 1'b0;
        hold(1);
        n_tests++;
        if (rd_valid !== 1'b0 || count !== 3'd0) begin
            n_fail++;
            $display("FAIL basic_pop: got v=%b cnt=%0d, want v=0 cnt=0", rd_valid, count);
        end
    endtask

    task automatic test_parity();
        int b_perr = n_perr;
        div = 8; par = 2'b10; stop2 = 1'b0;
        send_frame(1'b0, 8'h03, 8, 8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        hold(10);
        n_tests++;
        if (n_perr - b_perr != 1 || count !== 3'd0) begin
            n_fail++;
            $display("FAIL parity_bad: got pulses=%0d cnt=%0d, want pulses=1 cnt=0",
                     n_perr - b_perr, count);
        end
        send_frame(1'b0, 8'h03, 8, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        hold(10);
        n_tests++;
        if (n_perr - b_perr != 1 || count !== 3'd1 || rd_data !== 8'h03) begin
            n_fail++;
            $display("FAIL parity_good: got pulses=%0d cnt=%0d d=%h, want 1 1 03",
                     n_perr - b_perr, count, rd_data);
        end
        drain();
        par = 2'b00;
    endtask

    task automatic test_stop2_w7();
        int b_ferr7 = n_ferr7, b_perr7 = n_perr7;
        // 0x55 in 7 bits has four ones, so odd parity needs a parity bit of 1
        send_frame(1'b1, 8'h55, 7, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        hold(12);
        n_tests++;
        if (n_ferr7 - b_ferr7 != 1 || count7 !== 4'd0 || n_perr7 != b_perr7) begin
            n_fail++;
            $display("FAIL w7_stop2_low: got fe=%0d pe=%0d cnt=%0d, want fe=1 pe=0 cnt=0",
                     n_ferr7 - b_ferr7, n_perr7 - b_perr7, count7);
        end
        send_frame(1'b1, 8'h55, 7, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        hold(12);
        n_tests++;
        if (count7 !== 4'd1 || rd_data7 !== 7'h55 || n_ferr7 - b_ferr7 != 1) begin
            n_fail++;
            $display("FAIL w7_good: got cnt=%0d d=%h fe=%0d, want cnt=1 d=55 fe=1",
                     count7, rd_data7, n_ferr7 - b_ferr7);
        end
    endtask

    task automatic test_break();
        int b_ferr = n_ferr, b_brk = n_brk;
        div = 8; par = 2'b00; stop2 = 1'b0;
        rx = 1'b0;
        hold(20 * 8);
        n_tests++;
        if (brk !== 1'b1 || n_brk - b_brk != 1) begin
            n_fail++;
            $display("FAIL break_set: got brk=%b events=%0d, want 1 1", brk, n_brk - b_brk);
        end
        rx = 1'b1;
        hold(1);
        n_tests++;
        if (brk !== 1'b1) begin
            n_fail++;
            $display("FAIL break_hold: got brk=%b one cycle after release, want 1", brk);
        end
        hold(3);
        n_tests++;
        if (brk !== 1'b0 || n_ferr != b_ferr || count !== 3'd0) begin
            n_fail++;
            $display("FAIL break_clear: got brk=%b fe=%0d cnt=%0d, want 0 0 0",
                     brk, n_ferr - b_ferr, count);
        end
        hold(10);
    endtask

    task automatic test_overflow();
        int b_ovf = n_ovf;
        int p0 = popq.size();
        div = 8; par = 2'b00; stop2 = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send_8n1(8'(i), 8);
            hold(8);
        end
        n_tests++;
        if (n_ovf - b_ovf != 1 || count !== 3'd4) begin
            n_fail++;
            $display("FAIL ovf_full: got ovf=%0d cnt=%0d, want ovf=1 cnt=4", n_ovf - b_ovf, count);
        end
        drain();
        n_tests++;
        if (popq.size() - p0 != 4) begin
            n_fail++;
            $display("FAIL ovf_popn: got %0d pops, want 4", popq.size() - p0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (popq[p0 + i] !== 8'(i + 1)) begin
                    n_fail++;
                    $display("FAIL ovf_order[%0d]: got %h want %h", i, popq[p0 + i], 8'(i + 1));
                end
            end
        end
        // refill, then pop exactly in the push cycle of the fifth frame:
        // stop sample at edge 3+4+9*8=79 after the start edge, push at edge 80
        b_ovf = n_ovf;
        p0 = popq.size();
        for (int i = 1; i <= 4; i++) begin
            send_8n1(8'(i), 8);
            hold(8);
        end
        fork
            send_8n1(8'h05, 8);
            begin
                hold(79);
                rdy = 1'b1;
                hold(1);
                rdy = 1'b0;
            end
        join
        hold(10);
        n_tests++;
        if (n_ovf != b_ovf || count !== 3'd4) begin
            n_fail++;
            $display("FAIL ovf_pushpop: got ovf=%0d cnt=%0d, want ovf=0 cnt=4", n_ovf - b_ovf, count);
        end
        drain();
        n_tests++;
        if (popq.size() - p0 != 5) begin
            n_fail++;
            $display("FAIL ovf2_popn: got %0d pops, want 5", popq.size() - p0);
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_tests++;
                if (popq[p0 + i] !== 8'(i + 1)) begin
                    n_fail++;
                    $display("FAIL ovf2_order[%0d]: got %h want %h", i, popq[p0 + i], 8'(i + 1));
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        int b_ferr = n_ferr, b_perr = n_perr;
        div = 8; par = 2'b00; stop2 = 1'b0;
        send_8n1(8'h77, 8);
        hold(10);
        rx = 1'b0;                       // start bit of an interrupted frame
        hold(8);
        rx = 1'b1; hold(8);
        rx = 1'b0; hold(8);
        rx = 1'b1; hold(3);
        rstn = 1'b0;
        hold(2);
        n_tests++;
        if (count !== 3'd0 || rd_valid !== 1'b0 || rd_data !== 8'h00) begin
            n_fail++;
            $display("FAIL midreset_clear: got cnt=%0d v=%b d=%h, want 0 0 00", count, rd_valid, rd_data);
        end
        rstn = 1'b1;
        hold(20);
        send_8n1(8'h3C, 8);
        hold(10);
        n_tests++;
        if (count !== 3'd1 || rd_data !== 8'h3C || n_ferr != b_ferr || n_perr != b_perr) begin
            n_fail++;
            $display("FAIL midreset_rx: got cnt=%0d d=%h fe=%0d pe=%0d, want 1 3c 0 0",
                     count, rd_data, n_ferr - b_ferr, n_perr - b_perr);
        end
        drain();
        // one-cycle low glitch
        rx = 1'b0;
        hold(1);
        rx = 1'b1;
        hold(120);
        n_tests++;
        if (count !== 3'd0 || n_ferr != b_ferr || brk !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch: got cnt=%0d fe=%0d brk=%b, want 0 0 0", count, n_ferr - b_ferr, brk);
        end
    endtask

    task automatic test_clamp();
        div = 2; par = 2'b00; stop2 = 1'b0;
        send_8n1(8'h5A, 4);
        hold(10);
        n_tests++;
        if (count !== 3'd1 || rd_data !== 8'h5A) begin
            n_fail++;
            $display("FAIL clamp: got cnt=%0d d=%h, want 1 5a", count, rd_data);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int p0 = popq.size();
        logic [7:0] v [3];
        v[0] = 8'h11; v[1] = 8'hE2; v[2] = 8'h33;
        div = 6; par = 2'b00; stop2 = 1'b0;
        for (int i = 0; i < 3; i++) send_8n1(v[i], 6);
        hold(12);
        n_tests++;
        if (count !== 3'd3) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d want 3", count);
        end
        drain();
        n_tests++;
        if (popq.size() - p0 != 3) begin
            n_fail++;
            $display("FAIL b2b_popn: got %0d want 3", popq.size() - p0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (popq[p0 + i] !== v[i]) begin
                    n_fail++;
                    $display("FAIL b2b_data[%0d]: got %h want %h", i, popq[p0 + i], v[i]);
                end
            end
        end
    endtask

    // random frames, random settings changed mid-frame, random pop pacing
    task automatic test_random();
        logic [7:0] exp_q[$];
        int e_perr = 0, e_ferr = 0, e_brk = 0;
        int b_perr = n_perr, b_ferr = n_ferr, b_brk = n_brk, b_ovf = n_ovf;
        int p0 = popq.size();
        bit done = 1'b0;
        fork
            begin
                for (int f = 0; f < 40; f++) begin
                    int dv = $urandom_range(1, 12);
                    int bl = (dv < 4) ? 4 : dv;
                    logic [1:0] pm = 2'($urandom_range(0, 3));
                    bit s2m = 1'($urandom_range(0, 1));
                    logic [7:0] d = 8'($urandom_range(0, 255));
                    int c = $urandom_range(0, 4);
                    logic pb, s1, s2b, last_low;
                    if (f % 6 == 0) d = 8'h00;
                    pb = pm[0] ? ~^d : ^d;          // correct parity bit
                    if (c == 2) pb = ~pb;
                    s1  = (c != 3);
                    s2b = (c != 4);
                    if (!s1) begin
                        if (d == 8'h00 && (!pm[1] || !pb)) e_brk++;
                        else e_ferr++;
                    end else if (s2m && !s2b) begin
                        e_ferr++;
                    end else if (pm[1] && ((^d ^ pb) != pm[0])) begin
                        e_perr++;
                    end else begin
                        exp_q.push_back(d);
                    end
                    div = 32'(dv); par = pm; stop2 = s2m;
                    send_frame(1'b0, d, 8, bl, pm[1], pb, s1, s2m, s2b, 1'b1);
                    last_low = s2m ? !s2b : !s1;
                    hold($urandom_range(last_low ? 1 : 0, 2) * bl);
                end
                hold(40);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    rdy = 1'($urandom_range(0, 1));
                    hold(1);
                end
                rdy = 1'b0;
            end
        join
        drain();
        n_tests++;
        if (n_perr - b_perr != e_perr || n_ferr - b_ferr != e_ferr || n_brk - b_brk != e_brk) begin
            n_fail++;
            $display("FAIL rand_errors: got pe=%0d fe=%0d brk=%0d, want pe=%0d fe=%0d brk=%0d",
                     n_perr - b_perr, n_ferr - b_ferr, n_brk - b_brk, e_perr, e_ferr, e_brk);
        end
        n_tests++;
        if (n_ovf != b_ovf) begin
            n_fail++;
            $display("FAIL rand_ovf: got %0d want 0", n_ovf - b_ovf);
        end
        n_tests++;
        if (popq.size() - p0 != exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_popn: got %0d want %0d", popq.size() - p0, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_tests++;
                if (popq[p0 + i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL rand_data[%0d]: got %h want %h", i, popq[p0 + i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_stop2_w7();
        test_break();
        test_overflow();
        test_reset_midframe();
        test_clamp();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
